// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority pick: first set req bit at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned IDW = clog2(DEF_N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] winner_id,
  output logic [N-1:0]   winner_onehot
);

  always_comb begin
    int unsigned k;
    any           = 1'b0;
    winner_id     = '0;
    winner_onehot = '0;
    k             = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[IDW'(k)]) begin
        any                       = 1'b1;
        winner_id                 = IDW'(k);
        winner_onehot[IDW'(k)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-until-release grants and an optional hold timeout.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned IDW      = clog2(DEF_N),
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           timeout
);

  localparam int unsigned CW        = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           timeout_q, timeout_d;

  logic           release_c;
  logic           force_c;
  logic [IDW-1:0] next_ptr_c;
  logic [IDW-1:0] pick_ptr_c;
  logic           pick_any_c;
  logic [IDW-1:0] pick_id_c;
  logic [N-1:0]   pick_onehot_c;

  // Grant ends on a dropped request or when the hold budget is used up.
  always_comb begin
    next_ptr_c = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);
    release_c  = (state_q == GRANT) && !req[grant_id_q];
    force_c    = (state_q == GRANT) && req[grant_id_q] && (MAX_HOLD != 0) &&
                 (hold_cnt_q == CW'(HOLD_LAST));
    pick_ptr_c = (release_c || force_c) ? next_ptr_c : ptr_q;
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req           (req),
    .ptr           (pick_ptr_c),
    .any           (pick_any_c),
    .winner_id     (pick_id_c),
    .winner_onehot (pick_onehot_c)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d       = GRANT;
          grant_d       = pick_onehot_c;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_id_c;
          hold_cnt_d    = '0;
        end
      end
      GRANT: begin
        if (release_c || force_c) begin
          ptr_d      = next_ptr_c;
          timeout_d  = force_c;
          hold_cnt_d = '0;
          if (pick_any_c) begin
            grant_d       = pick_onehot_c;
            grant_valid_d = 1'b1;
            grant_id_d    = pick_id_c;
          end else begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
          end
        end else if (hold_cnt_q != '1) begin
          // Saturates only matter when the timeout is disabled.
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one registered 1-bit resource (a D flip-flop lane) between N requesters.
- Grants one requester at a time and holds the grant until that requester releases it, or until a hold-timeout forces release.
- Sits between the requester front-ends and the shared flop's clock-enable/data-select mux.
- All outputs are registered.

Parameters:
- N, 4, number of requesters; N >= 2.
- IDW, 2, width of grant_id; must equal clog2(N).
- MAX_HOLD, 8, maximum consecutive grant cycles per requester; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req  input  N  per-requester request level; a requester holds it high for the whole transfer.
- grant  output  N  one-hot grant; all-zero when idle.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  IDW  binary index of the granted requester; holds its last value when idle.
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Async reset (reset=0), effective immediately with no clock edge:
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
- Sampling: req is sampled only at rising clk edges. Combinational changes between edges have no effect.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at an edge, the winner is the first set bit searching cyclically from ptr upward (ptr, ptr+1, ..., wrapping to 0).
  - At that same edge: grant and grant_id are loaded, state becomes GRANT, hold_cnt becomes 0.
  - Latency from req sampled high to grant visible: one edge.
- GRANT, normal release:
  - If req[grant_id]=0 at an edge, the grant ends and ptr becomes (grant_id+1) mod N.
  - Re-arbitration happens in that same edge using the new ptr.
  - If another req bit is set, the next grant appears immediately with no idle bubble; otherwise grant=0 and state returns to IDLE.
- GRANT, hold:
  - If req[grant_id]=1 and (MAX_HOLD=0 or hold_cnt < MAX_HOLD-1), the grant is held and hold_cnt increments.
- GRANT, forced release:
  - Occurs when req[grant_id]=1, MAX_HOLD != 0 and hold_cnt = MAX_HOLD-1.
  - The grant ends, ptr becomes (grant_id+1) mod N, re-arbitration proceeds as in normal release, and timeout=1 for exactly the next cycle.
  - The preempted requester is now lowest priority. If it is the only requester, it is re-granted at the same edge with hold_cnt=0.
  - A granted requester holds the grant for at most MAX_HOLD consecutive cycles per grant.
- Non-granted req bits may toggle freely. They are only considered at arbitration edges.
- Invariants: grant is always one-hot or zero; grant_valid = |grant; grant_id matches grant whenever grant_valid=1.
- ptr wraps from N-1 to 0. hold_cnt is wide enough for MAX_HOLD-1 and never wraps.

Decomposition:
- Shared package arb_pkg:
  - State enum {IDLE, GRANT}.
  - clog2 constant function.
  - Default N and MAX_HOLD constants.
- One combinational sub-module rr_pick:
  - Inputs: req[N], ptr[IDW].
  - Outputs: any, winner_id[IDW], winner_onehot[N].
  - Used by rr_arbiter for every arbitration decision.

Test Plan:
- Reset check: hold reset=0 with req=1111 for 3 edges → grant=0000, grant_valid=0, grant_id=0, timeout=0. Release reset with req=1111 → first grant=0001, grant_id=0.
- Single requester: req=0100 sampled at edge k → grant=0100, grant_id=2 from edge k. Drop req before edge k+3 → grant=0000, grant_valid=0 after edge k+3.
- Rotation fairness: all four requesters assert and each drops req after 2 granted cycles, then immediately reasserts → grant_id sequence 0,1,2,3,0 with no idle cycles between grants.
- Pointer wrap: requester 2 granted and released while req=0011 → ptr=3, next grant=0001 (id 0), not 0010.
- Timeout (MAX_HOLD=8): req=0011 held constantly → id 0 granted exactly 8 cycles, timeout pulses 1 cycle, grant=0010, then 8 cycles later another timeout and grant back to 0001. req=0010 alone held for 20 cycles → timeout pulses every 8 cycles with grant staying 0010.
- Reset mid-grant: assert reset=0 between edges while grant=1000 → outputs clear immediately without a clock edge. Release reset with req=1010 → grant=0010 (ptr back to 0).
